ccff_prog_controller: RTL

// Sequences configuration of a chain of grid I/O tiles over the ccff_head/ccff_tail scan chain.
// - Flushes the chain to zero.
// - Measures the chain length with a marker bit.
// - Serialises a word-streamed bitstream into the chain, LSB first.
// - Holds IO_ISOL_N low (pads isolated) until a verified load completes.

---
 rtl/ccff_prog_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ccff_prog_controller.sv
// Programming sequencer for a ccff_head/ccff_tail configuration scan chain:
// flush to zero, measure the chain with a marker bit, then load a word-streamed bitstream.
module ccff_prog_controller #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  measured_len
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_PROBE = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam int BL_W = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [BL_W-1:0]  BL_ONE_C  = BL_W'(1);
    localparam logic [BL_W-1:0]  BL_REST_C = BL_W'(WORD_W - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wait_q, wait_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [BL_W-1:0]   left_q, left_d;
    logic              head_q, head_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;
    logic              iso_n_q, iso_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  meas_q, meas_d;
    logic              take_s;

    assign take_s = ready_q & bs_valid;

    // Next-state logic; head/shift_en are computed for the shift the chain takes on the next edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        sr_d    = sr_q;
        left_d  = left_q;
        head_d  = 1'b0;
        en_d    = 1'b0;
        iso_n_d = iso_n_q;
        done_d  = 1'b0;
        err_d   = err_q;
        meas_d  = meas_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_FLUSH;
                    err_d   = 1'b0;
                    meas_d  = '0;
                    iso_n_d = 1'b0;
                    en_d    = 1'b1;
                    cnt_d   = CNT_ONE_C;
                end else begin
                    state_d = state_q;
                end
            end
            S_FLUSH: begin
                en_d = 1'b1;
                if (cnt_q == LEN_C) begin
                    state_d = S_PROBE;
                    head_d  = 1'b1;
                    cnt_d   = CNT_ONE_C;
                    wait_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE_C;
                end
            end
            S_PROBE: begin
                // Shift and sample alternate so each probe shift is judged before the next one.
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    wait_d = 1'b0;
                    if (ccff_tail) begin
                        meas_d = cnt_q;
                        if (cnt_q == LEN_C) begin
                            state_d = S_LOAD;
                            cnt_d   = '0;
                            left_d  = '0;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end else if (cnt_q == LIMIT_C) begin
                        meas_d  = LIMIT_C;
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        en_d  = 1'b1;
                        cnt_d = cnt_q + CNT_ONE_C;
                    end
                end
            end
            S_LOAD: begin
                if (cnt_q == LEN_C) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    iso_n_d = 1'b1;
                    left_d  = '0;
                end else if (left_q != '0) begin
                    head_d = sr_q[0];
                    en_d   = 1'b1;
                    sr_d   = sr_q >> 1;
                    left_d = left_q - BL_ONE_C;
                    cnt_d  = cnt_q + CNT_ONE_C;
                end else if (take_s) begin
                    head_d = bs_data[0];
                    en_d   = 1'b1;
                    sr_d   = bs_data >> 1;
                    left_d = BL_REST_C;
                    cnt_d  = cnt_q + CNT_ONE_C;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                iso_n_d = 1'b0;
            end
        endcase

        busy_d  = (state_d == S_FLUSH) || (state_d == S_PROBE) || (state_d == S_LOAD);
        ready_d = (state_d == S_LOAD) && (left_d == '0) && (cnt_d != LEN_C);
    end

    // State and registered outputs; reset leaves the external chain untouched.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wait_q  <= 1'b0;
            sr_q    <= '0;
            left_q  <= '0;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            iso_n_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            meas_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            sr_q    <= sr_d;
            left_q  <= left_d;
            head_q  <= head_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            iso_n_q <= iso_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            meas_q  <= meas_d;
        end
    end

    assign bs_ready      = ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = en_q;
    assign IO_ISOL_N     = iso_n_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = err_q;
    assign measured_len  = meas_q;

endmodule
